// File: rtl/trng_pkg.sv
// Shared constants and helpers for the TRNG post-processing slice.
package trng_pkg;

  localparam int BYTE_W         = 8;
  localparam int REP_CUTOFF_DEF = 32;
  localparam int REP_W          = $clog2(255 + 1);
  localparam int PACK_W         = $clog2(BYTE_W);

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } pair_phase_e;

  // Saturating increment of the repetition counter.
  function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] cnt,
                                               input logic [REP_W-1:0] limit);
    if (cnt >= limit) return limit;
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/vn_debias.sv
// Von Neumann pair stage: 01 -> 0, 10 -> 1, equal pairs dropped.
//
// state     | meaning
// PH_FIRST  | next sampled bit is stored as the first of a pair
// PH_SECOND | next sampled bit is compared against the stored first bit
module vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_en,
  input  logic freeze,
  output logic vn_bit,
  output logic vn_valid
);

  pair_phase_e phase_q, phase_d;
  logic        first_q, first_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_FIRST;
      first_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      first_q <= first_d;
    end
  end

  // vn_valid qualifies the sample taken on this edge, so a byte can complete
  // on the same edge that samples its final raw bit.
  always_comb begin
    phase_d  = phase_q;
    first_d  = first_q;
    vn_bit   = first_q;
    vn_valid = 1'b0;
    if (bit_en && !freeze) begin
      case (phase_q)
        PH_FIRST: begin
          first_d = bit_in;
          phase_d = PH_SECOND;
        end
        PH_SECOND: begin
          phase_d  = PH_FIRST;
          vn_valid = first_q ^ bit_in;
        end
        default: phase_d = PH_FIRST;
      endcase
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processing: von Neumann debias, byte packer with single-entry
// valid/ready holder, and a repetition-count health test on the raw stream.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int REP_CUTOFF = REP_CUTOFF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              ovf,
  output logic              rep_fail
);

  localparam logic [REP_W-1:0]  CUTOFF    = REP_W'(REP_CUTOFF);
  localparam logic [PACK_W-1:0] PACK_LAST = PACK_W'(BYTE_W - 1);

  logic             prev_bit_q;
  logic             prev_valid_q;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_trip;
  logic             rep_fail_q;
  logic             freeze;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_trip  = 1'b0;
    if (bit_en) begin
      if (!prev_valid_q || (bit_in != prev_bit_q)) rep_cnt_d = REP_W'(1);
      else                                         rep_cnt_d = rep_inc(rep_cnt_q, CUTOFF);
      rep_trip = (rep_cnt_d == CUTOFF);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bit_q   <= 1'b0;
      prev_valid_q <= 1'b0;
      rep_cnt_q    <= '0;
      rep_fail_q   <= 1'b0;
    end else begin
      if (bit_en) begin
        prev_bit_q   <= bit_in;
        prev_valid_q <= 1'b1;
        rep_cnt_q    <= rep_cnt_d;
      end
      if (rep_trip) rep_fail_q <= 1'b1;
    end
  end

  // A trip on this edge already blocks any completion it coincides with.
  assign freeze = rep_fail_q | rep_trip;

  logic vn_bit, vn_valid;

  vn_debias u_vn_debias (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_en   (bit_en),
    .freeze   (freeze),
    .vn_bit   (vn_bit),
    .vn_valid (vn_valid)
  );

  logic [BYTE_W-2:0] shreg_q;
  logic [PACK_W-1:0] pack_cnt_q;
  logic [BYTE_W-1:0] packed_byte;
  logic              byte_done;

  assign packed_byte = {shreg_q, vn_bit};
  assign byte_done   = vn_valid && (pack_cnt_q == PACK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      pack_cnt_q <= '0;
    end else if (vn_valid) begin
      shreg_q    <= packed_byte[BYTE_W-2:0];
      pack_cnt_q <= pack_cnt_q + 1'b1;
    end
  end

  logic [BYTE_W-1:0] hold_q;
  logic              hold_valid_q;
  logic              ovf_q;
  logic              xfer;

  assign xfer = hold_valid_q & byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else if (rep_fail_q) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (byte_done) begin
      if (!hold_valid_q || xfer) begin
        hold_q       <= packed_byte;
        hold_valid_q <= 1'b1;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (xfer) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign byte_out   = hold_q;
  assign byte_valid = hold_valid_q;
  assign ovf        = ovf_q;
  assign rep_fail   = rep_fail_q;

endmodule
